// File: rtl/collision_monitor_pkg.sv
// collision_monitor_pkg: game state encodings shared with the game FSM, screen geometry
// and the confirm FSM states.
package collision_monitor_pkg;
    typedef enum logic [1:0] {
        GS_IDLE = 2'b00,
        GS_PLAY = 2'b01,
        GS_DEAD = 2'b10
    } gameState_e;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int X_W = $clog2(SCREEN_W);
    localparam int Y_W = $clog2(SCREEN_H);

    typedef enum logic [1:0] {
        ARMED,
        HIT,
        LATCHED
    } monState_e;
endpackage

// File: rtl/collision_monitor_if.sv
// collision_monitor_if: scan/coverage inputs from the video side and collision results back.
interface collision_monitor_if #(
    parameter int CNT_W = 12
);
    logic                                 pix_en;
    logic                                 frame_tick;
    logic [collision_monitor_pkg::X_W-1:0] vga_x;
    logic [collision_monitor_pkg::Y_W-1:0] vga_y;
    logic                                 dino_px;
    logic                                 obs_px;
    logic [1:0]                           game_state;
    logic                                 collided;
    logic                                 collide_pulse;
    logic [collision_monitor_pkg::X_W-1:0] hit_x;
    logic [collision_monitor_pkg::Y_W-1:0] hit_y;
    logic [CNT_W-1:0]                     last_overlap;

    modport master (
        output pix_en, frame_tick, vga_x, vga_y, dino_px, obs_px, game_state,
        input  collided, collide_pulse, hit_x, hit_y, last_overlap
    );

    modport slave (
        input  pix_en, frame_tick, vga_x, vga_y, dino_px, obs_px, game_state,
        output collided, collide_pulse, hit_x, hit_y, last_overlap
    );
endinterface

// File: rtl/collision_monitor_overlap_accum.sv
// collision_monitor_overlap_accum: gated saturating per-frame overlap counter with
// first-overlap coordinate capture; closeCnt/closeX/closeY already include a pixel coincident with frameTick.
module collision_monitor_overlap_accum
    import collision_monitor_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             countEn,
    input  logic             pixEn,
    input  logic             overlap,
    input  logic             frameTick,
    input  logic [X_W-1:0]   vgaX,
    input  logic [Y_W-1:0]   vgaY,
    output logic [CNT_W-1:0] closeCnt,
    output logic [X_W-1:0]   closeX,
    output logic [Y_W-1:0]   closeY,
    output logic [CNT_W-1:0] lastOverlap
);
    logic [CNT_W-1:0] ovlCnt;
    logic             capValid;
    logic [X_W-1:0]   capX;
    logic [Y_W-1:0]   capY;
    logic             hitPix;

    assign hitPix   = countEn && pixEn && overlap;
    assign closeCnt = (hitPix && ovlCnt != '1) ? ovlCnt + 1'b1 : ovlCnt;
    assign closeX   = capValid ? capX : (hitPix ? vgaX : '0);
    assign closeY   = capValid ? capY : (hitPix ? vgaY : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovlCnt      <= '0;
            capValid    <= 1'b0;
            capX        <= '0;
            capY        <= '0;
            lastOverlap <= '0;
        end else if (frameTick) begin
            ovlCnt      <= '0;
            capValid    <= 1'b0;
            capX        <= '0;
            capY        <= '0;
            lastOverlap <= closeCnt;
        end else begin
            ovlCnt      <= closeCnt;
            capValid    <= capValid || hitPix;
            capX        <= closeX;
            capY        <= closeY;
        end
    end
endmodule

// File: rtl/collision_monitor.sv
// collision_monitor: confirms dino/obstacle pixel overlap over consecutive hit frames
// and raises collided/collide_pulse for the game FSM.
module collision_monitor
    import collision_monitor_pkg::*;
#(
    parameter int PIX_THRESH = 4,
    parameter int CONFIRM_N  = 2,
    parameter int CNT_W      = 12
) (
    input logic                clk,
    input logic                rst,
    collision_monitor_if.slave bus
);
    localparam int STREAK_W = $clog2(CONFIRM_N + 1);

    monState_e           state;
    logic [STREAK_W-1:0] streak;
    logic                collided;
    logic                collidePulse;
    logic [X_W-1:0]      hitX;
    logic [Y_W-1:0]      hitY;
    logic [X_W-1:0]      closeX;
    logic [Y_W-1:0]      closeY;
    logic [CNT_W-1:0]    closeCnt;
    logic [CNT_W-1:0]    lastOverlap;
    logic                countEn;
    logic                frameHit;
    logic                confirm;

    // Overlap only accumulates while playing and not already latched.
    assign countEn  = bus.game_state == GS_PLAY && state == ARMED;
    assign frameHit = bus.game_state == GS_PLAY && closeCnt >= CNT_W'(PIX_THRESH);
    assign confirm  = int'(streak) + 1 >= CONFIRM_N;

    collision_monitor_overlap_accum #(
        .CNT_W(CNT_W)
    ) accum (
        .clk        (clk),
        .rst        (rst),
        .countEn    (countEn),
        .pixEn      (bus.pix_en),
        .overlap    (bus.dino_px && bus.obs_px),
        .frameTick  (bus.frame_tick),
        .vgaX       (bus.vga_x),
        .vgaY       (bus.vga_y),
        .closeCnt   (closeCnt),
        .closeX     (closeX),
        .closeY     (closeY),
        .lastOverlap(lastOverlap)
    );

    // HIT is the single cycle in which collide_pulse is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARMED;
            streak       <= '0;
            collided     <= 1'b0;
            collidePulse <= 1'b0;
            hitX         <= '0;
            hitY         <= '0;
        end else begin
            case (state)
                ARMED: begin
                    if (bus.frame_tick) begin
                        if (frameHit && confirm) begin
                            state        <= HIT;
                            collided     <= 1'b1;
                            collidePulse <= 1'b1;
                            hitX         <= closeX;
                            hitY         <= closeY;
                        end else begin
                            streak <= frameHit ? streak + 1'b1 : '0;
                        end
                    end
                end
                HIT: begin
                    collidePulse <= 1'b0;
                    state        <= LATCHED;
                end
                LATCHED: begin
                    if (bus.game_state == GS_IDLE) begin
                        state    <= ARMED;
                        streak   <= '0;
                        collided <= 1'b0;
                        hitX     <= '0;
                        hitY     <= '0;
                    end
                end
                default: state <= ARMED;
            endcase
        end
    end

    assign bus.collided      = collided;
    assign bus.collide_pulse = collidePulse;
    assign bus.hit_x         = hitX;
    assign bus.hit_y         = hitY;
    assign bus.last_overlap  = lastOverlap;
endmodule

// File: tb/tb_collision_monitor.sv
// tb_collision_monitor: directed and randomized frames checked against a per-frame
// reference model of the overlap/confirm rules.
module tb_collision_monitor;
    import collision_monitor_pkg::*;

    localparam int PIX_THRESH = 4;
    localparam int CONFIRM_N  = 2;
    localparam int CNT_W      = 12;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    collision_monitor_if #(.CNT_W(CNT_W)) bus();

    collision_monitor #(
        .PIX_THRESH(PIX_THRESH),
        .CONFIRM_N (CONFIRM_N),
        .CNT_W     (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int mStreak   = 0;
    bit mCollided = 1'b0;
    int mHitX     = 0;
    int mHitY     = 0;

    task automatic checkEq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.pix_en     = 1'b0;
        bus.frame_tick = 1'b0;
        bus.dino_px    = 1'b0;
        bus.obs_px     = 1'b0;
        bus.vga_x      = '0;
        bus.vga_y      = '0;
    endtask

    task automatic modelReset();
        mStreak   = 0;
        mCollided = 1'b0;
        mHitX     = 0;
        mHitY     = 0;
    endtask

    task automatic checkOutputs(input string tag);
        checkEq({tag, " collided"}, bus.collided, mCollided);
        checkEq({tag, " hit_x"}, bus.hit_x, mHitX);
        checkEq({tag, " hit_y"}, bus.hit_y, mHitY);
    endtask

    // One frame: nOvl overlap pixels under gs, separated by random non-overlap cycles,
    // then the frame_tick cycle under gsTick with an optional coincident overlap pixel.
    task automatic runFrame(input int nOvl, input logic [1:0] gs, input logic [1:0] gsTick,
                            input bit tickOvl, input int fx, input int fy, input string tag);
        int  cnt;
        int  firstX;
        int  firstY;
        int  x;
        int  y;
        int  fill;
        bit  pulse;
        bit  counting;
        bit  wasCollided;
        cnt    = 0;
        firstX = -1;
        firstY = -1;
        pulse  = 1'b0;
        bus.game_state = gs;
        if (mCollided && gs == GS_IDLE) modelReset();
        counting = gs == GS_PLAY && !mCollided;
        for (int i = 0; i < nOvl; i++) begin
            fill = $urandom_range(0, 1);
            for (int j = 0; j < fill; j++) begin
                bus.pix_en  = 1'($urandom);
                bus.dino_px = 1'($urandom);
                bus.obs_px  = (bus.pix_en && bus.dino_px) ? 1'b0 : 1'($urandom);
                bus.vga_x   = 10'($urandom_range(0, SCREEN_W - 1));
                bus.vga_y   = 9'($urandom_range(0, SCREEN_H - 1));
                step();
            end
            x = (i == 0 && fx >= 0) ? fx : $urandom_range(0, SCREEN_W - 1);
            y = (i == 0 && fy >= 0) ? fy : $urandom_range(0, SCREEN_H - 1);
            bus.pix_en  = 1'b1;
            bus.dino_px = 1'b1;
            bus.obs_px  = 1'b1;
            bus.vga_x   = 10'(x);
            bus.vga_y   = 9'(y);
            step();
            if (counting) begin
                if (firstX < 0) begin
                    firstX = x;
                    firstY = y;
                end
                cnt++;
            end
        end
        x = $urandom_range(0, SCREEN_W - 1);
        y = $urandom_range(0, SCREEN_H - 1);
        bus.game_state = gsTick;
        bus.frame_tick = 1'b1;
        bus.pix_en     = tickOvl;
        bus.dino_px    = tickOvl;
        bus.obs_px     = tickOvl;
        bus.vga_x      = 10'(x);
        bus.vga_y      = 9'(y);
        if (tickOvl && gsTick == GS_PLAY && !mCollided) begin
            if (firstX < 0) begin
                firstX = x;
                firstY = y;
            end
            cnt++;
        end
        if (cnt > CNT_MAX) cnt = CNT_MAX;
        wasCollided = mCollided;
        if (!mCollided) begin
            if (gsTick == GS_PLAY && cnt >= PIX_THRESH) begin
                mStreak++;
                if (mStreak >= CONFIRM_N) begin
                    mCollided = 1'b1;
                    pulse     = 1'b1;
                    mHitX     = firstX;
                    mHitY     = firstY;
                end
            end else begin
                mStreak = 0;
            end
        end
        step();
        idleInputs();
        if (!wasCollided) checkEq({tag, " last_overlap"}, bus.last_overlap, cnt);
        checkEq({tag, " pulse"}, bus.collide_pulse, pulse);
        checkOutputs(tag);
        step();
        checkEq({tag, " pulse_drop"}, bus.collide_pulse, 0);
        checkEq({tag, " collided_hold"}, bus.collided, mCollided);
    endtask

    initial begin
        logic [1:0] gs;
        logic [1:0] gsTick;
        int         r;
        idleInputs();
        bus.game_state = GS_PLAY;
        rst = 1'b1;
        // T1: activity during reset is ignored
        for (int i = 0; i < 3; i++) begin
            bus.pix_en     = 1'b1;
            bus.dino_px    = 1'b1;
            bus.obs_px     = 1'b1;
            bus.frame_tick = 1'($urandom);
            step();
        end
        checkEq("reset last_overlap", bus.last_overlap, 0);
        checkEq("reset pulse", bus.collide_pulse, 0);
        checkOutputs("reset");
        idleInputs();
        rst = 1'b0;
        step();

        // T2: below threshold never confirms
        for (int f = 0; f < 5; f++) runFrame(3, GS_PLAY, GS_PLAY, 1'b0, -1, -1, "sub");

        // T3: two hit frames confirm, coordinates from first overlap of confirming frame
        runFrame(10, GS_PLAY, GS_PLAY, 1'b0, 100, 50, "confirm1");
        runFrame(10, GS_PLAY, GS_PLAY, 1'b0, 200, 350, "confirm2");

        // T5: rearm from LATCHED on IDLE takes effect the next cycle
        bus.game_state = GS_IDLE;
        step();
        modelReset();
        checkOutputs("rearm");

        // T4: broken streak
        runFrame(5, GS_PLAY, GS_PLAY, 1'b0, -1, -1, "streak_hit1");
        runFrame(1, GS_PLAY, GS_PLAY, 1'b0, -1, -1, "streak_miss");
        runFrame(5, GS_PLAY, GS_PLAY, 1'b0, -1, -1, "streak_hit2");
        runFrame(5, GS_PLAY, GS_PLAY, 1'b0, 37, 411, "streak_hit3");

        // T5: overlaps outside PLAYING never count
        runFrame(8, GS_IDLE, GS_IDLE, 1'b1, -1, -1, "gate_idle");
        runFrame(8, GS_DEAD, GS_DEAD, 1'b1, -1, -1, "gate_dead");
        runFrame(6, GS_PLAY, GS_DEAD, 1'b0, -1, -1, "leave_play");

        // T6: saturation and coincident tick pixel
        runFrame(5000, GS_PLAY, GS_PLAY, 1'b0, -1, -1, "saturate");
        runFrame(3, GS_PLAY, GS_PLAY, 1'b1, -1, -1, "coincide");

        // Reset while latched
        rst = 1'b1;
        step();
        rst = 1'b0;
        modelReset();
        checkEq("rst_latched last_overlap", bus.last_overlap, 0);
        checkOutputs("rst_latched");

        for (int f = 0; f < 40; f++) begin
            r  = $urandom_range(0, 5);
            gs = (r == 0) ? GS_IDLE : (r == 1) ? GS_DEAD : GS_PLAY;
            gsTick = (gs == GS_PLAY && !mCollided && $urandom_range(0, 4) == 0) ? GS_DEAD : gs;
            runFrame($urandom_range(0, 8), gs, gsTick, 1'($urandom), -1, -1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
